// File: rtl/gnr_pkg.sv
// Shared constants and elaboration-time helpers for the GNR node LUT.
package gnr_pkg;

  // Width of the per-lane toggle counter.
  localparam int TGL_W = 16;

  // Ceiling log2, valid for value >= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // Number of truth-table entries for a node with numInputs regulators.
  function automatic int lut_bits(input int numInputs);
    return 1 << numInputs;
  endfunction

  // Number of config words needed to hold the whole truth table.
  function automatic int lut_words(input int numInputs, input int cfgW);
    return (lut_bits(numInputs) + cfgW - 1) / cfgW;
  endfunction

  // Config address width; at least one bit so the port always exists.
  function automatic int cfg_addr_w(input int numInputs, input int cfgW);
    int w;
    w = clog2(lut_words(numInputs, cfgW));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/gnr_lut_lane.sv
// One simulation lane of a GNR node: state register, update divider,
// changed flag, saturating unchanged-update counter with stable flag,
// and (when GNR_TOGGLE_CNT_EN is defined) a saturating toggle counter.
// The next-state value comes from the shared LUT in the parent.
module gnr_lut_lane
  import gnr_pkg::*;
#(
  parameter int SKIP_W     = 2,
  parameter int STB_W      = 4,
  parameter int STABLE_THR = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_reinit,
  input  logic              i_initState,
  input  logic [SKIP_W-1:0] i_skip,
  input  logic              i_start,
  input  logic              i_lutBit,
  output logic              o_state,
  output logic              o_changed,
  output logic              o_stable,
  output logic [TGL_W-1:0]  o_toggleCnt
);

  localparam logic [STB_W-1:0] STB_MAX = {STB_W{1'b1}};
  localparam logic [STB_W:0]   STB_THR = (STB_W + 1)'(STABLE_THR);

  logic              r_state;
  logic              r_changed;
  logic              r_stable;
  logic [SKIP_W-1:0] r_skip;
  logic [SKIP_W-1:0] r_div;
  logic [STB_W-1:0]  r_stbCnt;

  logic              w_update;
  logic              w_flip;
  logic [STB_W-1:0]  w_stbNext;

  // An update happens only on a start when the divider has run out; it flips
  // the state whenever the LUT output differs from the current state.
  always_comb begin
    w_update  = i_start && (r_div == '0);
    w_flip    = (i_lutBit != r_state);
    w_stbNext = r_stbCnt;
    if (w_flip) begin
      w_stbNext = '0;
    end else if (r_stbCnt != STB_MAX) begin
      w_stbNext = r_stbCnt + 1'b1;
    end
  end

  // Lane state machine: reset beats reinit, reinit beats start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= 1'b0;
      r_changed <= 1'b0;
      r_stable  <= 1'b0;
      r_skip    <= '0;
      r_div     <= '0;
      r_stbCnt  <= '0;
    end else if (i_reinit) begin
      r_state   <= i_initState;
      r_changed <= 1'b0;
      r_stable  <= 1'b0;
      r_skip    <= i_skip;
      r_div     <= '0;
      r_stbCnt  <= '0;
    end else if (w_update) begin
      r_state   <= i_lutBit;
      r_changed <= w_flip;
      r_stbCnt  <= w_stbNext;
      r_stable  <= ({1'b0, w_stbNext} >= STB_THR);
      r_div     <= r_skip;
    end else if (i_start) begin
      r_div     <= r_div - 1'b1;
    end
  end

  assign o_state   = r_state;
  assign o_changed = r_changed;
  assign o_stable  = r_stable;

`ifdef GNR_TOGGLE_CNT_EN
  logic [TGL_W-1:0] r_toggleCnt;

  // Count state flips; only reset clears it, reinit leaves history intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_toggleCnt <= '0;
    end else if (!i_reinit && w_update && w_flip && (r_toggleCnt != {TGL_W{1'b1}})) begin
      r_toggleCnt <= r_toggleCnt + 1'b1;
    end
  end

  assign o_toggleCnt = r_toggleCnt;
`else
  assign o_toggleCnt = '0;
`endif

endmodule

// File: rtl/gnr_node_lut.sv
// Programmable Boolean-network node with a runtime-loaded truth table shared
// by NUM_LANES independent simulation lanes. The LUT and its config port live
// here; each lane reads its entry combinationally from its in-vector slice.
// Optional feature macro: GNR_TOGGLE_CNT_EN (per-lane 16-bit toggle counters).
module gnr_node_lut
  import gnr_pkg::*;
#(
  parameter int NUM_LANES  = 2,
  parameter int NUM_INPUTS = 4,
  parameter int CFG_W      = 16,
  parameter int SKIP_W     = 2,
  parameter int STB_W      = 4,
  parameter int STABLE_THR = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_reinit,
  input  logic [NUM_LANES-1:0]                   i_initState,
  input  logic [NUM_LANES*SKIP_W-1:0]            i_laneSkip,
  input  logic [NUM_LANES-1:0]                   i_start,
  input  logic [NUM_LANES*NUM_INPUTS-1:0]        i_inVec,
  input  logic                                   i_cfgWe,
  input  logic [cfg_addr_w(NUM_INPUTS,CFG_W)-1:0] i_cfgAddr,
  input  logic [CFG_W-1:0]                       i_cfgWdata,
  output logic [NUM_LANES-1:0]                   o_state,
  output logic [NUM_LANES-1:0]                   o_changed,
  output logic [NUM_LANES-1:0]                   o_stable,
  output logic [NUM_LANES*TGL_W-1:0]             o_toggleCnt
);

  localparam int LUT_BITS  = lut_bits(NUM_INPUTS);
  localparam int LUT_WORDS = lut_words(NUM_INPUTS, CFG_W);
  localparam int ADDR_W    = cfg_addr_w(NUM_INPUTS, CFG_W);

  logic [LUT_WORDS*CFG_W-1:0] r_lut;
  logic [LUT_BITS-1:0]        w_lutBits;
  logic [NUM_LANES-1:0]       w_lutBit;

  // Word-wise LUT programming; addresses past the last word match nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lut <= '0;
    end else if (i_cfgWe) begin
      for (int w = 0; w < LUT_WORDS; w++) begin
        if (i_cfgAddr == ADDR_W'(w)) begin
          r_lut[w*CFG_W +: CFG_W] <= i_cfgWdata;
        end
      end
    end
  end

  // Padding bits in the last word never reach a lane.
  assign w_lutBits = r_lut[LUT_BITS-1:0];

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : gLane
      logic [NUM_INPUTS-1:0] w_idx;

      assign w_idx       = i_inVec[g*NUM_INPUTS +: NUM_INPUTS];
      assign w_lutBit[g] = w_lutBits[w_idx];

      gnr_lut_lane #(
        .SKIP_W     (SKIP_W),
        .STB_W      (STB_W),
        .STABLE_THR (STABLE_THR)
      ) uLane (
        .clk         (clk),
        .rst         (rst),
        .i_reinit    (i_reinit),
        .i_initState (i_initState[g]),
        .i_skip      (i_laneSkip[g*SKIP_W +: SKIP_W]),
        .i_start     (i_start[g]),
        .i_lutBit    (w_lutBit[g]),
        .o_state     (o_state[g]),
        .o_changed   (o_changed[g]),
        .o_stable    (o_stable[g]),
        .o_toggleCnt (o_toggleCnt[g*TGL_W +: TGL_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_gnr_node_lut.sv
// Directed self-checking bench for gnr_node_lut with default parameters.
// Expected toggle counts follow GNR_TOGGLE_CNT_EN at compile time.
module tb_gnr_node_lut;

`ifdef GNR_TOGGLE_CNT_EN
  localparam bit TGL_ON = 1'b1;
`else
  localparam bit TGL_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        reinit;
  logic [1:0]  initState;
  logic [3:0]  laneSkip;
  logic [1:0]  start;
  logic [7:0]  inVec;
  logic        cfgWe;
  logic [0:0]  cfgAddr;
  logic [15:0] cfgWdata;
  logic [1:0]  state;
  logic [1:0]  changed;
  logic [1:0]  stable;
  logic [31:0] toggleCnt;

  int nCompared = 0;
  int nFailed   = 0;

  gnr_node_lut dut (
    .clk         (clk),
    .rst         (rst),
    .i_reinit    (reinit),
    .i_initState (initState),
    .i_laneSkip  (laneSkip),
    .i_start     (start),
    .i_inVec     (inVec),
    .i_cfgWe     (cfgWe),
    .i_cfgAddr   (cfgAddr),
    .i_cfgWdata  (cfgWdata),
    .o_state     (state),
    .o_changed   (changed),
    .o_stable    (stable),
    .o_toggleCnt (toggleCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock one cycle with the currently driven inputs, then drop the strobes.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    reinit = 1'b0;
    start  = 2'b00;
    cfgWe  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic writeLut(input logic [0:0] addr, input logic [15:0] data);
    cfgWe    = 1'b1;
    cfgAddr  = addr;
    cfgWdata = data;
    applyStimulus();
  endtask

  initial begin
    logic [31:0] expTgl;
    rst = 1'b1; reinit = 1'b0; initState = 2'b00; laneSkip = 4'b0000;
    start = 2'b00; inVec = 8'h00; cfgWe = 1'b0; cfgAddr = 1'b0; cfgWdata = 16'h0000;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    checkOutput("reset_state", {30'd0, state}, 32'd0);
    checkOutput("reset_changed", {30'd0, changed}, 32'd0);
    checkOutput("reset_stable", {30'd0, stable}, 32'd0);
    checkOutput("reset_toggle", toggleCnt, 32'd0);

    // AND4: lane0 sees F -> 1, lane1 sees E -> 0
    writeLut(1'b0, 16'h8000);
    reinit = 1'b1; initState = 2'b00; laneSkip = 4'b0000;
    applyStimulus();
    inVec = 8'hEF; start = 2'b11;
    applyStimulus();
    checkOutput("and4_state", {30'd0, state}, 32'd1);
    checkOutput("and4_changed", {30'd0, changed}, 32'd1);
    start = 2'b11;
    applyStimulus();
    checkOutput("and4_changed2", {30'd0, changed}, 32'd0);
    checkOutput("and4_stable2", {30'd0, stable}, 32'd0);
    start = 2'b11;
    applyStimulus();
    checkOutput("and4_stable3", {30'd0, stable}, 32'd2);

    // Divider skip=1 on lane0: updates on pulses 1,3,5,7
    writeLut(1'b0, 16'hFFFF);
    reinit = 1'b1; initState = 2'b00; laneSkip = 4'b0001;
    applyStimulus();
    inVec = 8'hFF;
    for (int k = 1; k <= 7; k++) begin
      start = 2'b01;
      applyStimulus();
      checkOutput($sformatf("skip_state_p%0d", k), {30'd0, state}, 32'd1);
      checkOutput($sformatf("skip_changed_p%0d", k), {30'd0, changed}, (k <= 2) ? 32'd1 : 32'd0);
      checkOutput($sformatf("skip_stable_p%0d", k), {30'd0, stable}, (k == 7) ? 32'd1 : 32'd0);
    end

    // Held at 1: stable after 3rd unchanged update, counter saturates
    reinit = 1'b1; initState = 2'b11; laneSkip = 4'b0000;
    applyStimulus();
    for (int k = 1; k <= 20; k++) begin
      start = 2'b11;
      applyStimulus();
      checkOutput($sformatf("hold_stable_p%0d", k), {30'd0, stable}, (k >= 3) ? 32'd3 : 32'd0);
      checkOutput($sformatf("hold_changed_p%0d", k), {30'd0, changed}, 32'd0);
    end
    checkOutput("hold_state", {30'd0, state}, 32'd3);

    // Write and update in the same cycle: update uses the old LUT
    reinit = 1'b1; initState = 2'b00; laneSkip = 4'b0000; inVec = 8'h00;
    applyStimulus();
    start = 2'b01; cfgWe = 1'b1; cfgAddr = 1'b0; cfgWdata = 16'h0000;
    applyStimulus();
    checkOutput("wr_same_state", {30'd0, state}, 32'd1);
    start = 2'b01;
    applyStimulus();
    checkOutput("wr_after_state", {30'd0, state}, 32'd0);
    checkOutput("wr_after_changed", {30'd0, changed}, 32'd1);
    // Address 1 is past the only word and must be dropped
    writeLut(1'b1, 16'hFFFF);
    start = 2'b01;
    applyStimulus();
    checkOutput("bad_addr_state", {30'd0, state}, 32'd0);
    checkOutput("bad_addr_changed", {30'd0, changed}, 32'd0);

    // Reinit wins over a simultaneous start; divider restarts at 0
    writeLut(1'b0, 16'hFFFF);
    reinit = 1'b1; initState = 2'b10; laneSkip = 4'b0001; start = 2'b11; inVec = 8'hFF;
    applyStimulus();
    checkOutput("reinit_start_state", {30'd0, state}, 32'd2);
    checkOutput("reinit_start_changed", {30'd0, changed}, 32'd0);
    start = 2'b01;
    applyStimulus();
    checkOutput("post_reinit_state", {30'd0, state}, 32'd3);
    checkOutput("post_reinit_changed", {30'd0, changed}, 32'd1);
    start = 2'b01;
    applyStimulus();
    checkOutput("post_reinit_skip_changed", {30'd0, changed}, 32'd1);
    expTgl = TGL_ON ? {16'd0, 16'd5} : 32'd0;
    checkOutput("toggle_before_rst", toggleCnt, expTgl);

    // Mid-run reset clears everything including the LUT
    rst = 1'b1; start = 2'b11;
    applyStimulus();
    rst = 1'b0;
    checkOutput("midrst_state", {30'd0, state}, 32'd0);
    checkOutput("midrst_changed", {30'd0, changed}, 32'd0);
    checkOutput("midrst_stable", {30'd0, stable}, 32'd0);
    checkOutput("midrst_toggle", toggleCnt, 32'd0);
    start = 2'b11; inVec = 8'hFF;
    applyStimulus();
    checkOutput("lut_cleared_state", {30'd0, state}, 32'd0);

    // NOT(in0) with in0 fed back from state: oscillates every start
    writeLut(1'b0, 16'h5555);
    for (int k = 1; k <= 10; k++) begin
      inVec = {3'b000, state[1], 3'b000, state[0]};
      start = 2'b11;
      applyStimulus();
      checkOutput($sformatf("osc_state_p%0d", k), {30'd0, state}, (k % 2 == 1) ? 32'd3 : 32'd0);
    end
    expTgl = TGL_ON ? {16'd10, 16'd10} : 32'd0;
    checkOutput("osc_toggle", toggleCnt, expTgl);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
